rom_cpu_arbiter: RTL and testbench

ROM_CPU_ARBITER -- requirements
Module: rom_cpu_arbiter

---
 rtl/rom_arb_pkg.sv | 26 ++
 rtl/rom_arb_pick.sv | 34 +++
 rtl/rom_cpu_arbiter.sv | 144 ++++++++++++++
 tb/tb_rom_cpu_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM fetch arbiter: requester ids, FSM states and the
// fixed priority order table.
package rom_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_MAIN = 2'd0;
    localparam req_id_t REQ_CSD  = 2'd1;
    localparam req_id_t REQ_SND  = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    // Search order for the fixed-priority build: CSD, then main CPU, then sound CPU.
    localparam req_id_t PRIO_ORDER [NUM_REQ] = '{REQ_CSD, REQ_MAIN, REQ_SND};

    function automatic req_id_t next_id(input req_id_t id);
        return (id >= REQ_SND) ? REQ_MAIN : req_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner selector. Fixed-priority table walk by default; with
// ROM_ARB_ROUND_ROBIN_EN defined the search walks requester ids starting at start_i.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending_i,
    input  req_id_t            start_i,
    output req_id_t            id_o,
    output logic               any_o
);

    req_id_t slot;
    req_id_t cand;

    always_comb begin
        id_o  = REQ_MAIN;
        any_o = 1'b0;
        slot  = start_i;
        cand  = REQ_MAIN;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            cand = slot;
`else
            cand = PRIO_ORDER[slot];
`endif
            if (!any_o && pending_i[cand]) begin
                id_o  = cand;
                any_o = 1'b1;
            end
            slot = next_id(slot);
        end
    end

endmodule

// File: rtl/rom_cpu_arbiter.sv
// Arbitrates three CPU ROM fetch ports onto one toggle-handshake SDRAM read port, caching the
// last word per requester. Define ROM_ARB_ROUND_ROBIN_EN for rotating priority.
module rom_cpu_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        dl_active,
    input  logic [NUM_REQ-1:0][AW-1:0]  req_addr,
    output logic [NUM_REQ-1:0][DW-1:0]  req_q,
    output logic [NUM_REQ-1:0]          req_busy,
    output logic                        mem_req,
    input  logic                        mem_ack,
    output logic [AW-1:0]               mem_addr,
    input  logic [DW-1:0]               mem_q
);

    state_e                       state_q, state_d;
    req_id_t                      id_q, id_d;
    logic [AW-1:0]                mem_addr_q, mem_addr_d;
    logic                         mem_req_q, mem_req_d;
    logic [NUM_REQ-1:0][DW-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0][AW-1:0]   last_addr_q, last_addr_d;
    logic [NUM_REQ-1:0]           valid_q, valid_d;
    logic                         dl_q;

    logic                         dl_fall;
    logic                         ack_match;
    logic [NUM_REQ-1:0]           valid_eff;
    logic [NUM_REQ-1:0]           pending;
    req_id_t                      pick_start;
    req_id_t                      pick_id;
    logic                         pick_any;

    assign dl_fall   = dl_q & ~dl_active;
    assign ack_match = (mem_ack == mem_req_q);
    // A falling download edge invalidates the cache in the very cycle it is seen.
    assign valid_eff = dl_fall ? '0 : valid_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pending[i] = ~valid_eff[i] | (req_addr[i] != last_addr_q[i]);
        end
    end

`ifdef ROM_ARB_ROUND_ROBIN_EN
    req_id_t ptr_q, ptr_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ptr_q <= REQ_MAIN;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && !dl_active && pick_any && ack_match) begin
            ptr_d = next_id(pick_id);
        end
    end

    assign pick_start = ptr_q;
`else
    assign pick_start = req_id_t'(0);
`endif

    rom_arb_pick u_pick (
        .pending_i (pending),
        .start_i   (pick_start),
        .id_o      (pick_id),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        data_d      = data_q;
        last_addr_d = last_addr_q;
        valid_d     = valid_q;

        unique case (state_q)
            StIdle: begin
                // ack_match also keeps us parked after a reset that left a read in flight.
                if (!dl_active && pick_any && ack_match) begin
                    id_d       = pick_id;
                    mem_addr_d = req_addr[pick_id];
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                mem_req_d = ~mem_req_q;
                state_d   = StWait;
            end
            StWait: begin
                if (ack_match) begin
                    data_d[id_q]      = mem_q;
                    last_addr_d[id_q] = mem_addr_q;
                    valid_d[id_q]     = 1'b1;
                    state_d           = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (dl_fall) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            id_q        <= REQ_MAIN;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            data_q      <= '0;
            last_addr_q <= '0;
            valid_q     <= '0;
            dl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            valid_q     <= valid_d;
            dl_q        <= dl_active;
        end
    end

    assign req_q    = data_q;
    assign req_busy = pending;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_rom_cpu_arbiter.sv
// Bench for rom_cpu_arbiter: toggle-handshake SDRAM model with a fixed read delay and an
// address scoreboard filled as stimulus is driven and drained as requests appear.
module tb_rom_cpu_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DELAY = 4;

    logic                clk_sys = 1'b0;
    logic                reset = 1'b0;
    logic                dl_active = 1'b1;
    logic [2:0][AW-1:0]  req_addr = '0;
    logic [2:0][DW-1:0]  req_q;
    logic [2:0]          req_busy;
    logic                mem_req;
    logic                mem_ack = 1'b0;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_q = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW-1:0] exp_q [$];
    int            toggles = 0;
    int            done = 0;
    int            mdl_cnt = 0;
    logic          mdl_on = 1'b0;
    logic          prev_req = 1'b0;
    logic          abandoned = 1'b0;
    logic [AW-1:0] mdl_addr = '0;
    logic          ack_force_en = 1'b0;
    logic          ack_force_val = 1'b0;
    int            bench_ptr = 0;

    rom_cpu_arbiter #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .dl_active (dl_active),
        .req_addr  (req_addr),
        .req_q     (req_q),
        .req_busy  (req_busy),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [DW-1:0] mdl_data(input logic [AW-1:0] a);
        if (a == 16'h0123) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    function automatic int next_winner(input logic [2:0] mask, input int start);
        int order [3];
        int c;
        order = '{1, 0, 2};
        for (int k = 0; k < 3; k++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            c = (start + k) % 3;
`else
            c = order[k];
`endif
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    // Push expected fetch addresses for requesters in mask, all pending together.
    task automatic expect_round(input logic [2:0] mask);
        logic [2:0] m;
        int w;
        m = mask;
        while (m != 3'b000) begin
            w = next_winner(m, bench_ptr);
            exp_q.push_back(req_addr[w]);
            m[w] = 1'b0;
            bench_ptr = (w + 1) % 3;
        end
    endtask

    task automatic model_step();
        logic [AW-1:0] e;
        if (!mdl_on) return;
        if (reset) begin
            prev_req = 1'b0;
            if (mdl_cnt > 0) abandoned = 1'b1;
        end
        if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                if (!abandoned) begin
                    n_cmp++;
                    if (mem_addr !== mdl_addr) begin
                        n_fail++;
                        $display("FAIL addr_stable: mem_addr %h, required %h", mem_addr, mdl_addr);
                    end
                end
                mem_q   = mdl_data(mdl_addr);
                mem_ack = ~mem_ack;
                done++;
            end
        end
        if (ack_force_en) mem_ack = ack_force_val;
        if (!reset && mem_req !== prev_req) begin
            prev_req = mem_req;
            toggles++;
            n_cmp++;
            if (mdl_cnt > 0) begin
                n_fail++;
                $display("FAIL single_outstanding: new toggle with %0d cycles left, required 0",
                         mdl_cnt);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_req: mem_addr %h, required no request", mem_addr);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e) begin
                    n_fail++;
                    $display("FAIL grant_addr: mem_addr %h, required %h", mem_addr, e);
                end
            end
            mdl_addr  = mem_addr;
            mdl_cnt   = DELAY;
            abandoned = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        model_step();
    endtask

    task automatic wait_done(input int target, input string what);
        int n = 0;
        while (done < target && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (done < target) begin
            n_fail++;
            $display("FAIL %s: completions %0d, required %0d", what, done, target);
        end
        tick();
    endtask

    task automatic wait_toggle(input int target, input string what);
        int n = 0;
        while (toggles < target && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (toggles < target) begin
            n_fail++;
            $display("FAIL %s: toggles %0d, required %0d", what, toggles, target);
        end
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        #1;
        mdl_on = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_req: got %b, required 0", mem_req);
        end
        n_cmp++;
        if (mem_addr !== '0) begin
            n_fail++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr);
        end
        n_cmp++;
        if (req_q !== '0) begin
            n_fail++; $display("FAIL reset_req_q: got %h, required 0", req_q);
        end
        n_cmp++;
        if (req_busy !== 3'b111) begin
            n_fail++; $display("FAIL reset_busy: got %b, required 111", req_busy);
        end
        reset = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (toggles !== 0) begin
            n_fail++; $display("FAIL dl_hold_after_reset: toggles %0d, required 0", toggles);
        end
    endtask

    task automatic test_first_round();
        int d0 = done;
        req_addr[0] = 16'h0123;
        req_addr[1] = 16'h1111;
        req_addr[2] = 16'h2222;
        expect_round(3'b111);
        dl_active = 1'b0;
        wait_done(d0 + 3, "first_round_done");
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (req_q[i] !== mdl_data(req_addr[i])) begin
                n_fail++;
                $display("FAIL first_round_q%0d: got %h, required %h", i, req_q[i],
                         mdl_data(req_addr[i]));
            end
        end
        n_cmp++;
        if (req_q[0] !== 16'hBEEF) begin
            n_fail++; $display("FAIL beef_word: got %h, required beef", req_q[0]);
        end
        n_cmp++;
        if (req_busy !== 3'b000 || toggles !== 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL first_round_state: busy %b toggles %0d left %0d, required 000 3 0",
                     req_busy, toggles, exp_q.size());
        end
    endtask

    task automatic test_addr_change();
        int d0 = done;
        int t0 = toggles;
        req_addr[1] = 16'h8000;
        expect_round(3'b010);
        wait_toggle(t0 + 1, "change_first_toggle");
        req_addr[1] = 16'h8001;
        expect_round(3'b010);
        wait_done(d0 + 1, "change_first_done");
        n_cmp++;
        if (req_q[1] !== mdl_data(16'h8000) || req_busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL change_stale_data: q1 %h busy1 %b, required %h 1", req_q[1],
                     req_busy[1], mdl_data(16'h8000));
        end
        wait_done(d0 + 2, "change_refetch_done");
        n_cmp++;
        if (req_q[1] !== mdl_data(16'h8001) || req_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL change_refetch: q1 %h busy1 %b, required %h 0", req_q[1],
                     req_busy[1], mdl_data(16'h8001));
        end
    endtask

    task automatic test_dl_active();
        int d0 = done;
        int t0 = toggles;
        req_addr[0] = 16'h0456;
        expect_round(3'b001);
        wait_toggle(t0 + 1, "dl_toggle");
        dl_active = 1'b1;
        wait_done(d0 + 1, "dl_read_completes");
        n_cmp++;
        if (req_q[0] !== mdl_data(16'h0456)) begin
            n_fail++;
            $display("FAIL dl_read_data: got %h, required %h", req_q[0], mdl_data(16'h0456));
        end
        req_addr[2] = 16'h2A2A;
        t0 = toggles;
        repeat (20) tick();
        n_cmp++;
        if (toggles !== t0) begin
            n_fail++; $display("FAIL dl_no_grant: toggles %0d, required %0d", toggles, t0);
        end
        expect_round(3'b111);
        d0 = done;
        dl_active = 1'b0;
        #1;
        n_cmp++;
        if (req_busy !== 3'b111) begin
            n_fail++; $display("FAIL dl_fall_busy: got %b, required 111", req_busy);
        end
        wait_done(d0 + 3, "dl_refetch_done");
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (req_q[i] !== mdl_data(req_addr[i])) begin
                n_fail++;
                $display("FAIL dl_refetch_q%0d: got %h, required %h", i, req_q[i],
                         mdl_data(req_addr[i]));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int d0 = done;
        int t0 = toggles;
        req_addr[1] = 16'h9999;
        expect_round(3'b010);
        wait_toggle(t0 + 1, "rst_toggle");
        tick();
        reset = 1'b1;
        dl_active = 1'b1;
        bench_ptr = 0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || req_q !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: mem_req %b req_q %h, required 0 0", mem_req, req_q);
        end
        tick();
        tick();
        reset = 1'b0;
        t0 = toggles;
        wait_done(d0 + 1, "stale_ack");
        repeat (5) tick();
        n_cmp++;
        if (req_q !== '0 || toggles !== t0) begin
            n_fail++;
            $display("FAIL stale_ack_write: req_q %h toggles %0d, required 0 %0d", req_q,
                     toggles, t0);
        end
        ack_force_val = 1'b1;
        ack_force_en  = 1'b1;
        tick();
        dl_active = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (toggles !== t0) begin
            n_fail++;
            $display("FAIL ack_inconsistent_hold: toggles %0d, required %0d", toggles, t0);
        end
        expect_round(3'b111);
        d0 = done;
        ack_force_val = 1'b0;
        tick();
        ack_force_en = 1'b0;
        wait_done(d0 + 3, "post_reset_round");
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (req_q[i] !== mdl_data(req_addr[i])) begin
                n_fail++;
                $display("FAIL post_reset_q%0d: got %h, required %h", i, req_q[i],
                         mdl_data(req_addr[i]));
            end
        end
    endtask

    task automatic test_idle_hold();
        int t0 = toggles;
        repeat (100) tick();
        n_cmp++;
        if (toggles !== t0 || req_busy !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_hold: toggles %0d busy %b, required %0d 000", toggles,
                     req_busy, t0);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: left %0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_addr_change();
        test_dl_active();
        test_reset_mid_wait();
        test_idle_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
